pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle EXE stalls with timeout,
// and branch/jump redirect with a multi-cycle flush window.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned EXE_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_reg1_raddr_i,
    input  logic [4:0]  id_reg2_raddr_i,
    input  logic        id_reg1_re_i,
    input  logic        id_reg2_re_i,
    input  logic [4:0]  exe_reg_waddr_i,
    input  logic        exe_reg_we_i,
    input  logic        exe_is_load_i,
    input  logic        exe_mc_start_i,
    input  logic        exe_mc_done_i,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    output logic [4:0]  stall_o,
    output logic [1:0]  bubble_o,
    output logic        flush_o,
    output logic        pc_we_o,
    output logic [31:0] pc_o,
    output logic        err_o,
    output logic [15:0] stall_cnt_o,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXE_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(EXE_TIMEOUT - 1);

    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_LU   = 5'b00011;
    localparam logic [4:0] STALL_MC   = 5'b00111;

    state_e      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;

    assign load_use = exe_is_load_i && exe_reg_we_i && (exe_reg_waddr_i != 5'd0) &&
                      ((id_reg1_re_i && (id_reg1_raddr_i == exe_reg_waddr_i)) ||
                       (id_reg2_re_i && (id_reg2_raddr_i == exe_reg_waddr_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 2'd0;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // While rst_i is low every combinational output is forced to its idle value.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        stall_o     = STALL_NONE;
        bubble_o    = 2'b00;
        flush_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_o        = 32'd0;

        if (rst_i) begin
            unique case (state_q)
                ST_RUN: begin
                    if (jump_req_i) begin
                        flush_o = 1'b1;
                        pc_we_o = 1'b1;
                        pc_o    = jump_addr_i;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_INIT;
                        end
                    end else if (exe_mc_start_i) begin
                        stall_o    = STALL_MC;
                        bubble_o   = 2'b10;
                        state_d    = ST_EXE_WAIT;
                        wait_cnt_d = 8'd0;
                    end else if (load_use) begin
                        stall_o  = STALL_LU;
                        bubble_o = 2'b01;
                    end
                end

                ST_FLUSH: begin
                    flush_o = 1'b1;
                    if (flush_cnt_q <= 2'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 2'd0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end

                ST_EXE_WAIT: begin
                    // Done wins over timeout when both land on the same cycle.
                    if (exe_mc_done_i) begin
                        state_d = ST_RUN;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        stall_o    = STALL_MC;
                        bubble_o   = 2'b10;
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o[0] && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign state_dbg_o = state_q;

endmodule
